// File: rtl/score_disp_pkg.sv
// score_disp_pkg
//   Shared definitions for the score display driver: conversion FSM state
//   encoding, special segment patterns, the BCD digit to segment table and a
//   small elaboration-time helper for the overflow threshold.
//   Segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package score_disp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Digit-to-pattern table; any code above 9 shows nothing.
   function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = 7'b1000000;
         4'd1:    pattern = 7'b1111001;
         4'd2:    pattern = 7'b0100100;
         4'd3:    pattern = 7'b0110000;
         4'd4:    pattern = 7'b0011001;
         4'd5:    pattern = 7'b0010010;
         4'd6:    pattern = 7'b0000010;
         4'd7:    pattern = 7'b1111000;
         4'd8:    pattern = 7'b0000000;
         4'd9:    pattern = 7'b0010000;
         default: pattern = SEG_BLANK;
      endcase
      return pattern;
   endfunction

   // 10^n, used at elaboration for the overflow threshold.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational decoder for one seven-segment digit.
//   Ports:
//     digit  in   4  BCD digit to show
//     blank  in   1  show nothing (leading-zero suppression)
//     dash   in   1  show a dash; wins over blank and digit
//     seg_n  out  7  active-low segments, bit 0 = a ... bit 6 = g
module seg7_decode
   import score_disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_BLANK;
      if (dash) begin
         seg_n = SEG_DASH;
      end else if (!blank) begin
         seg_n = digit_to_seg(digit);
      end
   end

endmodule

// File: rtl/score_display_driver.sv
// score_display_driver
//   Accepts a binary score, converts it to BCD with a sequential double
//   dabble (one input bit per clock) and drives a multiplexed common-anode
//   seven-segment display with leading-zero blanking, overflow dashes and an
//   optional whole-display blink.
//   Ports:
//     clk, rst            clock; asynchronous active-high reset
//     bin_in, in_valid    value to show and its valid strobe
//     in_ready            high while idle (transfer = in_valid & in_ready)
//     blank_lz, blink_en  display options, live (no conversion needed)
//     conv_done           one-cycle pulse when bcd_out/overflow update
//     overflow            last accepted value >= 10^NUM_DIGITS
//     bcd_out             displayed digits, ones in [3:0]
//     an_n, seg_n         registered active-low anode select / segments
module score_display_driver
   import score_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int BIN_W      = 10,
   parameter int SCAN_DIV   = 50000,
   parameter int BLINK_DIV  = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BIN_W-1:0]        bin_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    blank_lz,
   input  logic                    blink_en,
   output logic                    conv_done,
   output logic                    overflow,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic [6:0]              seg_n
);

   localparam int          BCD_W     = 4 * NUM_DIGITS;
   localparam int          CNT_W     = $clog2(BIN_W + 1);
   localparam int          IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int          PRE_W     = $clog2(SCAN_DIV);
   localparam int          FRM_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

   state_t             state_reg, state_next;
   logic               transfer, last_step;
   logic [BIN_W-1:0]   shift_reg;
   logic [BCD_W-1:0]   scratch_reg, scratch_adj, scratch_next, bcd_reg;
   logic [CNT_W-1:0]   bit_cnt_reg;
   logic               ovf_pend_reg, overflow_reg, conv_done_reg;
   logic               ovf_in;

   logic [PRE_W-1:0]   pre_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic [FRM_W-1:0]   frm_reg;
   logic               phase_on_reg, show;
   logic               scan_tick, last_idx, frame_wrap;
   logic [3:0]         digit_arr [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] lead_blank;
   logic               zero_run;
   logic [6:0]         seg_dec;
   logic [NUM_DIGITS-1:0] an_n_reg;
   logic [6:0]         seg_n_reg;

   // ---------------- conversion FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      transfer   = 1'b0;
      last_step  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               transfer   = 1'b1;
               state_next = CONVERT;
            end
         end
         CONVERT: begin
            if (bit_cnt_reg == CNT_W'(BIN_W - 1)) begin
               last_step  = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign ovf_in = (64'(bin_in) >= OVF_LIMIT);

   // Double dabble: add 3 to every nibble >= 5, then shift in the next bit.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [3:0] nib;
         assign nib                   = scratch_reg[4*gi +: 4];
         assign scratch_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
         assign digit_arr[gi]         = bcd_reg[4*gi +: 4];
      end
   endgenerate

   assign scratch_next = {scratch_adj[BCD_W-2:0], shift_reg[BIN_W-1]};

   // bcd_out is loaded on the final shift so it is visible together with
   // the conv_done pulse during DONE; it holds its old value while converting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg     <= '0;
         scratch_reg   <= '0;
         bit_cnt_reg   <= '0;
         ovf_pend_reg  <= 1'b0;
         bcd_reg       <= '0;
         overflow_reg  <= 1'b0;
         conv_done_reg <= 1'b0;
      end else begin
         conv_done_reg <= last_step;
         if (transfer) begin
            shift_reg    <= bin_in;
            scratch_reg  <= '0;
            bit_cnt_reg  <= '0;
            ovf_pend_reg <= ovf_in;
         end else if (state_reg == CONVERT) begin
            shift_reg   <= shift_reg << 1;
            scratch_reg <= scratch_next;
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
         end
         if (last_step) begin
            bcd_reg      <= scratch_next;
            overflow_reg <= ovf_pend_reg;
         end
      end
   end

   // ---------------- display scan ----------------
   assign scan_tick  = (pre_reg == PRE_W'(SCAN_DIV - 1));
   assign last_idx   = (idx_reg == IDX_W'(NUM_DIGITS - 1));
   assign frame_wrap = scan_tick && last_idx;
   // Disabling blink shows the display on the very next output update,
   // not one clock later via the phase register.
   assign show       = phase_on_reg || !blink_en;

   // Blank every digit above the most significant nonzero one; the ones
   // digit is never blanked so a zero score still reads "0".
   always_comb begin
      lead_blank = '0;
      zero_run   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run      = zero_run && (digit_arr[i] == 4'd0);
         lead_blank[i] = zero_run && blank_lz;
      end
   end

   seg7_decode u_seg7_decode (
      .digit (digit_arr[idx_reg]),
      .blank (lead_blank[idx_reg]),
      .dash  (overflow_reg),
      .seg_n (seg_dec)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_reg      <= '0;
         idx_reg      <= '0;
         frm_reg      <= '0;
         phase_on_reg <= 1'b1;
         an_n_reg     <= '1;
         seg_n_reg    <= SEG_BLANK;
      end else begin
         pre_reg <= scan_tick ? '0 : pre_reg + PRE_W'(1);
         if (scan_tick) begin
            idx_reg <= last_idx ? '0 : idx_reg + IDX_W'(1);
         end
         if (!blink_en) begin
            frm_reg      <= '0;
            phase_on_reg <= 1'b1;
         end else if (frame_wrap) begin
            if (frm_reg == FRM_W'(BLINK_DIV - 1)) begin
               frm_reg      <= '0;
               phase_on_reg <= !phase_on_reg;
            end else begin
               frm_reg <= frm_reg + FRM_W'(1);
            end
         end
         an_n_reg  <= show ? ~(NUM_DIGITS'(1) << idx_reg) : '1;
         seg_n_reg <= show ? seg_dec : SEG_BLANK;
      end
   end

   assign conv_done = conv_done_reg;
   assign overflow  = overflow_reg;
   assign bcd_out   = bcd_reg;
   assign an_n      = an_n_reg;
   assign seg_n     = seg_n_reg;

endmodule

// File: doc/score_display_driver.md
SCORE_DISPLAY_DRIVER -- requirements
Module: score_display_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3, number of decimal digits and anodes driven.
REQ-002 SHALL have parameter BIN_W, default 10, width of the binary value input.
REQ-003 SHALL have parameter SCAN_DIV, default 50000, clocks per digit scan slot (minimum 2).
REQ-004 SHALL have parameter BLINK_DIV, default 64, full scan frames per blink half-period (minimum 1).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port bin_in  input  BIN_W  unsigned binary value to display.
REQ-008 SHALL have port in_valid  input  1  bin_in is valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a value; high exactly in IDLE.
REQ-010 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-011 SHALL have port blink_en  input  1  whole-display blink enable.
REQ-012 SHALL have port conv_done  output  1  one-cycle pulse when the display register updates.
REQ-013 SHALL have port overflow  output  1  latched: last accepted value is at least 10^NUM_DIGITS.
REQ-014 SHALL have port bcd_out  output  4*NUM_DIGITS  displayed BCD digits; digit 0 (ones) in bits [3:0].
REQ-015 SHALL have port an_n  output  NUM_DIGITS  active-low one-hot anode select; bit 0 = ones digit.
REQ-016 SHALL have port seg_n  output  7  active-low segments; bit 0 = a … bit 6 = g.

Function
REQ-017 Transfer SHALL occur on a clock where in_valid and in_ready are both high; in_valid outside IDLE SHALL be ignored.
REQ-018 FSM SHALL have states IDLE, CONVERT, DONE: IDLE->CONVERT on transfer; CONVERT lasts exactly BIN_W cycles; DONE lasts 1 cycle; DONE->IDLE.
REQ-019 CONVERT SHALL be sequential shift-add-3 (double dabble), one input bit per cycle, MSB first, over a 4*NUM_DIGITS scratch register.
REQ-020 On transfer, overflow SHALL be computed from bin_in >= 10^NUM_DIGITS and held for that value.
REQ-021 In DONE, bcd_out SHALL load the scratch result, overflow SHALL update, and conv_done SHALL be high; with the transfer at cycle 0, this occurs in cycle BIN_W+1.
REQ-022 bcd_out and the displayed value SHALL hold the previous result throughout CONVERT.
REQ-023 Digit patterns SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, written g..a. A non-BCD code SHALL give blank (1111111).
REQ-024 When overflow is high, every digit SHALL show dash (0111111), regardless of blank_lz.
REQ-025 When blank_lz is high, digits above the most significant nonzero digit SHALL be blank; digit 0 SHALL never blank, so value 0 shows "0".
REQ-026 The prescaler SHALL count 0..SCAN_DIV-1. At terminal count, digit index SHALL advance and wrap from NUM_DIGITS-1 to 0.
REQ-027 an_n and seg_n SHALL be registered and SHALL change together, one clock after the index changes.
REQ-028 With blink_en high, a frame counter SHALL count index wraps. Every BLINK_DIV frames the blink phase SHALL toggle; in the off phase an_n SHALL be all ones and seg_n all ones.
REQ-029 When blink_en is low, the frame counter SHALL clear and the phase SHALL be forced on within one clock.
REQ-030 Changes to blank_lz SHALL take effect at the next registered output update, without waiting for a conversion.

Reset
REQ-031 rst high SHALL asynchronously set state IDLE, bcd_out 0, overflow 0, conv_done 0, prescaler 0, digit index 0, frame counter 0, blink phase on, an_n all ones, seg_n all ones.
REQ-032 in_ready SHALL be 1 while rst is high and after reset.
REQ-033 Reset during CONVERT SHALL abort the conversion with no conv_done pulse and bcd_out = 0.

Structure
REQ-034 Package score_disp_pkg SHALL hold the FSM state enum, constants SEG_BLANK and SEG_DASH, and the digit-to-pattern table.
REQ-035 Combinational sub-module seg7_decode (4-bit digit, blank, dash in; 7-bit seg_n out) SHALL be instantiated once, on the muxed current digit.

Verification (SCAN_DIV=4, BLINK_DIV=2, defaults otherwise)
REQ-036 Scenario: bin_in=300 with in_valid pulsed in IDLE -> in_ready low for 11 cycles; conv_done at cycle 11; bcd_out=0x300; digits scan 0,0,3.
REQ-037 Scenario: bin_in=7 with blank_lz=1 -> an_n bits 2 and 1 show seg_n=1111111; bit 0 shows 1111000. With blank_lz=0 -> 1000000 on bits 2 and 1.
REQ-038 Scenario: bin_in=1023 -> overflow=1 and all digits 0111111; then bin_in=0 with blank_lz=1 -> overflow=0, only the ones digit lit with 1000000.
REQ-039 Scenario: new in_valid during CONVERT of 123 -> ignored; bcd_out=0x123; exactly one conv_done pulse.
REQ-040 Scenario: blink_en=1 -> an_n all ones for 2 frames (24 clk), then scans for 2 frames, repeating; blink_en=0 -> scanning resumes within 1 clock.
REQ-041 Scenario: rst asserted mid-CONVERT -> outputs at reset values immediately; no conv_done; next transfer of 45 completes normally.
